stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Sequencing controller for the stopwatch time-register datapath. It conditions the raw start and lap buttons, generates the count-rate tick from the system clock, and runs the run/pause/lap/terminal state machine. It drives the datapath's next-value select (`T_s`), load enable (`T_ld`), lap capture and display select. It sits between the board buttons and the BCD time register / comparator (`T_comp`).

## Interface
- `DIV`, 1000000: clock cycles per count tick (100 MHz gives 10 ms). Must be at least 2.
- `DB_CYCLES`, 1000000: consecutive stable synchronized samples required to accept a new button level. Must be at least 1.
- `clk` input 1: system clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: raw start/stop button, asynchronous to `clk`.
- `lap` input 1: raw lap/clear button, asynchronous to `clk`.
- `T_comp` input 1: datapath flag; time register holds terminal value 99:59.99. Synchronous to `clk`.
- `T_s` output 2: datapath next-value select. 00 = load zero, 01 = load incremented, 10 = hold.
- `T_ld` output 1: time-register load enable.
- `lap_cap` output 1: one-cycle pulse; lap register captures the live time.
- `disp_sel` output 1: 0 = display live time, 1 = display lap register.
- `running` output 1: high in RUN.
- `tick` output 1: one-cycle increment strobe (same cycle as `T_s`=01).

## Operation
- **Button conditioning (per button, identical):**
  - 2-flop synchronizer, then a counter.
  - The debounced level changes only after the synchronized input differs from it for `DB_CYCLES` consecutive cycles. Any bounce restarts the count.
  - A press is a one-cycle pulse on the debounced level's 0→1 edge. Releases produce nothing.
- **States:** IDLE, RUN, PAUSE, DONE. Encoding is free.
- **Transitions, evaluated per edge in the listed priority:**
  - IDLE:
    - start press and `T_comp`=0 → RUN.
    - Otherwise stay.
  - RUN:
    - `T_comp`=1 → DONE.
    - start press → PAUSE.
    - lap press → toggle `disp_sel`, stay in RUN. On a 0→1 toggle, pulse `lap_cap`.
  - PAUSE:
    - start press and `T_comp`=0 → RUN.
    - lap press with `disp_sel`=1 → clear `disp_sel`, stay in PAUSE.
    - lap press with `disp_sel`=0 → IDLE.
  - DONE:
    - lap press → IDLE.
    - start press is ignored.
- Entering IDLE clears `disp_sel`.
- A simultaneous start press and lap press is resolved by the priority above. The lost press is discarded, not queued.
- **Prescaler:**
  - Counts 0..`DIV`-1 only while in RUN and `T_comp`=0.
  - Holds in PAUSE and DONE, so resume keeps the fractional period.
  - Cleared to 0 in IDLE.
  - On the edge where the count equals `DIV`-1 and the next state is RUN:
    - the count wraps to 0;
    - `tick` sets for exactly one cycle.
  - If the next state is not RUN, no tick is generated and the count holds.
- **Output decode (registered state and tick only; no combinational path from inputs):**
  - IDLE: `T_s`=00, `T_ld`=1.
  - RUN with `tick`=1: `T_s`=01, `T_ld`=1.
  - All other cases: `T_s`=10, `T_ld`=0.
- **Reset values:**
  - state IDLE, prescaler 0, synchronizers and debounced levels 0, debounce counters 0.
  - `T_s`=00, `T_ld`=1, `tick`=0, `lap_cap`=0, `disp_sel`=0, `running`=0.
- Reset mid-RUN or mid-debounce aborts immediately. A button still held at reset release becomes debounced high after `DB_CYCLES` cycles and produces one press.

## Timing
- Button latency: raw edge → press pulse is 2 (sync) + `DB_CYCLES` + 1 cycles, given clean input.
- Press pulse → state change on that same cycle's closing edge. `running` and outputs reflect the new state in the next cycle.
- The first tick after IDLE→RUN occurs `DIV` cycles after the RUN entry edge. Ticks are then exactly `DIV` cycles apart.
- `T_comp` high while in RUN → DONE on the next edge. No tick is issued on that edge, even if the count was `DIV`-1.
- `lap_cap` is asserted in the cycle after the lap press. The datapath captures the time present in that cycle.

## Test plan
- **Reset/idle.** `DIV`=4, `DB_CYCLES`=3; assert then deassert `rst` → `T_s`=00, `T_ld`=1, `tick`=0, `disp_sel`=0, `running`=0. Hold for 20 cycles with no change.
- **Debounce.** Toggle `start` 1/0 every 2 cycles for 12 cycles, then hold at 1 → exactly one press, 6 cycles after the final rising edge. State goes to RUN.
- **Run cadence.** Start from IDLE → `tick` at cycles 4, 8, 12 after RUN entry, each with `T_s`=01 and `T_ld`=1. `T_s`=10 and `T_ld`=0 between ticks.
- **Pause/resume fraction.** Pause 2 cycles after a tick, wait 50 cycles, resume → next tick 2 cycles after the RUN re-entry edge.
- **Lap.** In RUN, lap press → one `lap_cap` pulse, `disp_sel`=1, ticks continue. Second lap → `disp_sel`=0, no `lap_cap`. In PAUSE, lap with `disp_sel`=0 → IDLE, `T_s`=00.
- **Terminal.** Drive `T_comp`=1 on the cycle the count is at `DIV`-1 → no tick, DONE, `T_s`=10. Start press is ignored. Lap press → IDLE.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: button conditioning, count-rate prescaler and the
// IDLE/RUN/PAUSE/DONE machine driving the time-register select/load and lap display.
module stopwatch_ctrl #(
    parameter int DIV       = 1000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       lap,
    input  logic       T_comp,
    output logic [1:0] T_s,
    output logic       T_ld,
    output logic       lap_cap,
    output logic       disp_sel,
    output logic       running,
    output logic       tick,
    output logic [1:0] state_dbg
);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int PW  = $clog2(DIV);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [PW-1:0]  P_LAST  = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bit 0 is the start button, bit 1 the lap button.
    logic [1:0]     raw, sync1, sync2, db, db_d, press;
    logic [DBW-1:0] db_cnt [2];

    assign raw = {lap, start};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            press <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_d  <= db;
            press <= db & ~db_d;
            for (int i = 0; i < 2; i++) begin
                // Any sample agreeing with the current level restarts the count.
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DBW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    state_t        state, nxt;
    logic [PW-1:0] pcnt;
    logic          start_p, lap_p, tick_nxt;

    assign start_p   = press[0];
    assign lap_p     = press[1];
    assign state_dbg = state;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start_p && !T_comp) nxt = RUN;
            RUN: begin
                if (T_comp)       nxt = DONE;
                else if (start_p) nxt = PAUSE;
            end
            PAUSE: begin
                if (start_p && !T_comp)    nxt = RUN;
                else if (lap_p && !disp_sel) nxt = IDLE;
            end
            DONE:    if (lap_p) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign tick_nxt = (state == RUN) && !T_comp && (pcnt == P_LAST) && (nxt == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pcnt     <= '0;
            tick     <= 1'b0;
            lap_cap  <= 1'b0;
            disp_sel <= 1'b0;
            running  <= 1'b0;
            T_s      <= 2'b00;
            T_ld     <= 1'b1;
        end else begin
            state   <= nxt;
            tick    <= tick_nxt;
            running <= (nxt == RUN);
            lap_cap <= 1'b0;

            // Prescaler holds outside RUN so a resume keeps the fractional period.
            if (state == IDLE) begin
                pcnt <= '0;
            end else if (state == RUN && !T_comp) begin
                if (pcnt == P_LAST) begin
                    if (nxt == RUN) pcnt <= '0;
                end else begin
                    pcnt <= pcnt + PW'(1);
                end
            end

            if (nxt == IDLE) begin
                disp_sel <= 1'b0;
            end else if (state == RUN && !T_comp && !start_p && lap_p) begin
                disp_sel <= ~disp_sel;
                lap_cap  <= ~disp_sel;
            end else if (state == PAUSE && !(start_p && !T_comp) && lap_p && disp_sel) begin
                disp_sel <= 1'b0;
            end

            case (nxt)
                IDLE: begin
                    T_s  <= 2'b00;
                    T_ld <= 1'b1;
                end
                RUN: begin
                    T_s  <= tick_nxt ? 2'b01 : 2'b10;
                    T_ld <= tick_nxt;
                end
                default: begin
                    T_s  <= 2'b10;
                    T_ld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=4, DB_CYCLES=3; all stimulus changes
// 1 time unit after a rising edge and outputs are sampled at the same point.
module tb_stopwatch_ctrl;

    localparam int DIV = 4;
    localparam int DB  = 3;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic       clk = 1'b0;
    logic       rst, start, lap, T_comp;
    logic [1:0] T_s, state_dbg;
    logic       T_ld, lap_cap, disp_sel, running, tick;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int tick_q[$];
    int cap_q[$];

    stopwatch_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .lap      (lap),
        .T_comp   (T_comp),
        .T_s      (T_s),
        .T_ld     (T_ld),
        .lap_cap  (lap_cap),
        .disp_sel (disp_sel),
        .running  (running),
        .tick     (tick),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Advance one edge; cyc is the index of the edge just taken.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (tick === 1'b1) tick_q.push_back(cyc);
        if (lap_cap === 1'b1) cap_q.push_back(cyc);
    endtask

    // Clean press: the press pulse follows 6 edges after the raw rise and the
    // state acts on the 7th edge, where this task returns.
    task automatic press(input bit s, input bit l);
        start = s;
        lap   = l;
        repeat (6) step();
        start = 1'b0;
        lap   = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [8:0] exp_v;
        exp_v = {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE};
        rst = 1'b1; start = 1'b0; lap = 1'b0; T_comp = 1'b0;
        repeat (3) step();
        checks++;
        if ({T_s, T_ld, tick, lap_cap, disp_sel, running, state_dbg} !== exp_v) begin
            failures++;
            $display("FAIL reset_held got=%b exp=%b", {T_s, T_ld, tick, lap_cap, disp_sel, running, state_dbg}, exp_v);
        end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if ({T_s, T_ld, tick, lap_cap, disp_sel, running, state_dbg} !== exp_v) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, {T_s, T_ld, tick, lap_cap, disp_sel, running, state_dbg}, exp_v);
            end
        end
    endtask

    task automatic test_debounce();
        for (int p = 0; p < 3; p++) begin
            start = 1'b1; step(); step();
            start = 1'b0; step(); step();
        end
        checks++;
        if (running !== 1'b0 || state_dbg !== S_IDLE) begin
            failures++;
            $display("FAIL debounce_bounce got running=%b state=%0d exp running=0 state=%0d", running, state_dbg, S_IDLE);
        end
        start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++;
            if (running !== (k == 7)) begin
                failures++;
                $display("FAIL debounce_latency edge=%0d got running=%b exp=%b", k, running, (k == 7));
            end
        end
        checks++;
        if (state_dbg !== S_RUN) begin
            failures++;
            $display("FAIL debounce_state got=%0d exp=%0d", state_dbg, S_RUN);
        end
    endtask

    task automatic test_run_cadence();
        logic [3:0] exp_v;
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_v = (k % 4 == 0) ? 4'b1011 : 4'b0100;
            checks++;
            if ({tick, T_s, T_ld} !== exp_v || running !== 1'b1) begin
                failures++;
                $display("FAIL run_cadence k=%0d got tick,T_s,T_ld=%b running=%b exp=%b running=1", k, {tick, T_s, T_ld}, running, exp_v);
            end
        end
    endtask

    task automatic test_pause_resume();
        int a, r;
        a = cyc - 12;
        repeat (3) step();
        tick_q.delete();
        press(1'b1, 1'b0);
        checks++;
        if (cyc != a + 22 || tick_q.size() != 2 || tick_q[0] != a + 16 || tick_q[1] != a + 20) begin
            failures++;
            $display("FAIL pause_ticks got n=%0d pause_edge=%0d exp ticks at %0d,%0d pause_edge=%0d", tick_q.size(), cyc, a + 16, a + 20, a + 22);
        end
        checks++;
        if (state_dbg !== S_PAUSE || running !== 1'b0 || T_s !== 2'b10 || T_ld !== 1'b0 || tick !== 1'b0) begin
            failures++;
            $display("FAIL pause_state got state=%0d running=%b T_s=%b T_ld=%b tick=%b exp 2,0,10,0,0", state_dbg, running, T_s, T_ld, tick);
        end
        tick_q.delete();
        repeat (50) step();
        checks++;
        if (tick_q.size() != 0 || state_dbg !== S_PAUSE) begin
            failures++;
            $display("FAIL pause_hold got ticks=%0d state=%0d exp 0 ticks state=%0d", tick_q.size(), state_dbg, S_PAUSE);
        end
        press(1'b1, 1'b0);
        r = cyc;
        checks++;
        if (state_dbg !== S_RUN || running !== 1'b1 || tick !== 1'b0) begin
            failures++;
            $display("FAIL resume_state got state=%0d running=%b tick=%b exp 1,1,0", state_dbg, running, tick);
        end
        step();
        checks++;
        if (tick !== 1'b0) begin
            failures++;
            $display("FAIL resume_early edge=%0d got tick=%b exp 0", cyc - r, tick);
        end
        step();
        checks++;
        if ({tick, T_s, T_ld} !== 4'b1011) begin
            failures++;
            $display("FAIL resume_fraction edge=%0d got tick,T_s,T_ld=%b exp 1011", cyc - r, {tick, T_s, T_ld});
        end
    endtask

    task automatic test_lap();
        int l;
        cap_q.delete();
        press(1'b0, 1'b1);
        l = cyc;
        checks++;
        if (lap_cap !== 1'b1 || disp_sel !== 1'b1 || running !== 1'b1) begin
            failures++;
            $display("FAIL lap_first got lap_cap=%b disp_sel=%b running=%b exp 1,1,1", lap_cap, disp_sel, running);
        end
        step();
        checks++;
        if (lap_cap !== 1'b0 || tick !== 1'b1) begin
            failures++;
            $display("FAIL lap_pulse_tick got lap_cap=%b tick=%b exp lap_cap=0 tick=1", lap_cap, tick);
        end
        repeat (4) step();
        press(1'b0, 1'b1);
        checks++;
        if (disp_sel !== 1'b0 || lap_cap !== 1'b0 || running !== 1'b1) begin
            failures++;
            $display("FAIL lap_second got disp_sel=%b lap_cap=%b running=%b exp 0,0,1", disp_sel, lap_cap, running);
        end
        step();
        checks++;
        if (cap_q.size() != 1 || cap_q[0] != l) begin
            failures++;
            $display("FAIL lap_cap_count got n=%0d exp 1 pulse at edge %0d", cap_q.size(), l);
        end
        press(1'b1, 1'b0);
        checks++;
        if (state_dbg !== S_PAUSE || disp_sel !== 1'b0) begin
            failures++;
            $display("FAIL lap_pause got state=%0d disp_sel=%b exp %0d,0", state_dbg, disp_sel, S_PAUSE);
        end
        repeat (5) step();
        press(1'b0, 1'b1);
        checks++;
        if (state_dbg !== S_IDLE || T_s !== 2'b00 || T_ld !== 1'b1 || running !== 1'b0) begin
            failures++;
            $display("FAIL lap_to_idle got state=%0d T_s=%b T_ld=%b running=%b exp 0,00,1,0", state_dbg, T_s, T_ld, running);
        end
    endtask

    task automatic test_terminal();
        repeat (5) step();
        press(1'b1, 1'b0);
        checks++;
        if (state_dbg !== S_RUN) begin
            failures++;
            $display("FAIL term_start got state=%0d exp %0d", state_dbg, S_RUN);
        end
        repeat (3) step();
        T_comp = 1'b1;
        step();
        checks++;
        if (tick !== 1'b0 || state_dbg !== S_DONE || T_s !== 2'b10 || T_ld !== 1'b0 || running !== 1'b0) begin
            failures++;
            $display("FAIL term_done got tick=%b state=%0d T_s=%b T_ld=%b running=%b exp 0,3,10,0,0", tick, state_dbg, T_s, T_ld, running);
        end
        repeat (5) step();
        press(1'b1, 1'b0);
        step();
        checks++;
        if (state_dbg !== S_DONE || running !== 1'b0) begin
            failures++;
            $display("FAIL term_start_ignored got state=%0d running=%b exp %0d,0", state_dbg, running, S_DONE);
        end
        repeat (5) step();
        press(1'b0, 1'b1);
        checks++;
        if (state_dbg !== S_IDLE || T_s !== 2'b00 || T_ld !== 1'b1) begin
            failures++;
            $display("FAIL term_lap_idle got state=%0d T_s=%b T_ld=%b exp 0,00,1", state_dbg, T_s, T_ld);
        end
        T_comp = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        repeat (5) step();
        press(1'b1, 1'b0);
        repeat (5) step();
        cap_q.delete();
        press(1'b1, 1'b1);
        checks++;
        if (state_dbg !== S_PAUSE || disp_sel !== 1'b0) begin
            failures++;
            $display("FAIL b2b_priority got state=%0d disp_sel=%b exp %0d,0", state_dbg, disp_sel, S_PAUSE);
        end
        step();
        checks++;
        if (cap_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_no_cap got n=%0d exp 0", cap_q.size());
        end
        repeat (5) step();
        press(1'b0, 1'b1);
        checks++;
        if (state_dbg !== S_IDLE || running !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle got state=%0d running=%b exp 0,0", state_dbg, running);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_run_cadence();
        test_pause_resume();
        test_lap();
        test_terminal();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
